// File: rtl/frog_session_ctrl.sv
// Purpose : Frogger game-session FSM (IDLE/RUNNING/DYING/GAME_OVER) with lives, BCD level and death flash.
// Latency : 1 cycle from sampled input to registered outputs.
// Backpressure: none; inputs are sampled every cycle and outputs are plain registered levels/pulses.
//
// Ports:
//   i_Clk, i_Reset (async, active-high)
//   i_Start        - ANDed debounced switches, rising-edge detected
//   i_Has_Collided - frog overlaps a car (level)
//   i_Level_Up     - frog reached the top row, rising-edge detected
//   o_Game_Active  - high only in RUNNING
//   o_State        - 0=IDLE 1=RUNNING 2=DYING 3=GAME_OVER
//   o_Lives, o_Level_Ones/Tens, o_Respawn (1-cycle on DYING->RUNNING), o_Death_Flash
//   o_Best_Ones/Tens - best level reached; only live when FROG_SESSION_HIGH_SCORE_EN is defined
module frog_session_ctrl #(
    parameter int C_LIVES_INI    = 3,
    parameter int C_DEATH_CYCLES = 25_000_000,
    parameter int C_FLASH_CYCLES = 3_125_000
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic       i_Start,
    input  logic       i_Has_Collided,
    input  logic       i_Level_Up,
    output logic       o_Game_Active,
    output logic [1:0] o_State,
    output logic [1:0] o_Lives,
    output logic [3:0] o_Level_Ones,
    output logic [3:0] o_Level_Tens,
    output logic       o_Respawn,
    output logic       o_Death_Flash,
    output logic [3:0] o_Best_Ones,
    output logic [3:0] o_Best_Tens
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RUNNING   = 2'd1,
        ST_DYING     = 2'd2,
        ST_GAME_OVER = 2'd3
    } state_t;

    localparam int DW = $clog2(C_DEATH_CYCLES);
    // A one-cycle flash half-period still needs a 1-bit counter to exist.
    localparam int FW = (C_FLASH_CYCLES > 1) ? $clog2(C_FLASH_CYCLES) : 1;
    localparam logic [DW-1:0] DEATH_LAST = DW'(C_DEATH_CYCLES - 1);
    localparam logic [FW-1:0] FLASH_LAST = FW'(C_FLASH_CYCLES - 1);
    localparam logic [1:0]    LIVES_INI  = 2'(C_LIVES_INI);

    state_t          state_q, state_d;
    logic [1:0]      lives_q, lives_d;
    logic [3:0]      ones_q, ones_d, tens_q, tens_d;
    logic [DW-1:0]   death_cnt_q, death_cnt_d;
    logic [FW-1:0]   flash_cnt_q, flash_cnt_d;
    logic            flash_q, flash_d;
    logic            respawn_q, respawn_d;
    logic            active_q, active_d;
    logic            start_prev_q, lvl_prev_q;

    logic start_edge, lvl_edge, death_done, level_max;

    assign start_edge = i_Start & ~start_prev_q;
    assign lvl_edge   = i_Level_Up & ~lvl_prev_q;
    assign death_done = (death_cnt_q == DEATH_LAST);
    assign level_max  = (tens_q == 4'd9) && (ones_q == 4'd9);

    // State and datapath registers
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            state_q      <= ST_IDLE;
            lives_q      <= 2'd0;
            ones_q       <= 4'd0;
            tens_q       <= 4'd0;
            death_cnt_q  <= '0;
            flash_cnt_q  <= '0;
            flash_q      <= 1'b0;
            respawn_q    <= 1'b0;
            active_q     <= 1'b0;
            start_prev_q <= 1'b0;
            lvl_prev_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            lives_q      <= lives_d;
            ones_q       <= ones_d;
            tens_q       <= tens_d;
            death_cnt_q  <= death_cnt_d;
            flash_cnt_q  <= flash_cnt_d;
            flash_q      <= flash_d;
            respawn_q    <= respawn_d;
            active_q     <= active_d;
            start_prev_q <= i_Start;
            lvl_prev_q   <= i_Level_Up;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (start_edge) state_d = ST_RUNNING;
            ST_RUNNING:   if (i_Has_Collided) state_d = ST_DYING;
            // Lives were already decremented on entry, so 0 here means the last life is gone.
            ST_DYING:     if (death_done) state_d = (lives_q == 2'd0) ? ST_GAME_OVER : ST_RUNNING;
            ST_GAME_OVER: if (start_edge) state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    // Output / datapath next values (registered above)
    always_comb begin
        lives_d     = lives_q;
        ones_d      = ones_q;
        tens_d      = tens_q;
        death_cnt_d = death_cnt_q;
        flash_cnt_d = flash_cnt_q;
        flash_d     = 1'b0;
        respawn_d   = 1'b0;
        active_d    = (state_d == ST_RUNNING);
        case (state_q)
            ST_IDLE: begin
                if (start_edge) begin
                    lives_d = LIVES_INI;
                    ones_d  = 4'd0;
                    tens_d  = 4'd0;
                end
            end
            ST_RUNNING: begin
                // Collision has priority: a simultaneous level-up is dropped.
                if (i_Has_Collided) begin
                    lives_d     = lives_q - 2'd1;
                    death_cnt_d = '0;
                    flash_cnt_d = '0;
                    flash_d     = 1'b1;
                end else if (lvl_edge && !level_max) begin
                    if (ones_q == 4'd9) begin
                        ones_d = 4'd0;
                        tens_d = tens_q + 4'd1;
                    end else begin
                        ones_d = ones_q + 4'd1;
                    end
                end
            end
            ST_DYING: begin
                if (death_done) respawn_d = (lives_q != 2'd0);
                else            death_cnt_d = death_cnt_q + 1'b1;
                if (flash_cnt_q == FLASH_LAST) begin
                    flash_cnt_d = '0;
                    flash_d     = ~flash_q;
                end else begin
                    flash_cnt_d = flash_cnt_q + 1'b1;
                    flash_d     = flash_q;
                end
            end
            ST_GAME_OVER: begin
                if (start_edge) begin
                    ones_d = 4'd0;
                    tens_d = 4'd0;
                end
            end
            default: ;
        endcase
        // Flash is only visible while dying; this also clears it on the exit cycle.
        if (state_d != ST_DYING) flash_d = 1'b0;
    end

    assign o_State       = state_q;
    assign o_Game_Active = active_q;
    assign o_Lives       = lives_q;
    assign o_Level_Ones  = ones_q;
    assign o_Level_Tens  = tens_q;
    assign o_Respawn     = respawn_q;
    assign o_Death_Flash = flash_q;

`ifdef FROG_SESSION_HIGH_SCORE_EN
    logic [3:0] best_ones_q, best_tens_q;

    // BCD digit pairs compare correctly as a plain 8-bit number (tens in the high nibble).
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            best_ones_q <= 4'd0;
            best_tens_q <= 4'd0;
        end else if (state_q == ST_DYING && state_d == ST_GAME_OVER &&
                     {tens_q, ones_q} > {best_tens_q, best_ones_q}) begin
            best_ones_q <= ones_q;
            best_tens_q <= tens_q;
        end
    end

    assign o_Best_Ones = best_ones_q;
    assign o_Best_Tens = best_tens_q;
`else
    assign o_Best_Ones = 4'd0;
    assign o_Best_Tens = 4'd0;
`endif

endmodule

// File: doc/frog_session_ctrl.md
# frog_session_ctrl

Game-session controller between the debounced switch/collision/level-up signals and the gameplay blocks in the Frogger top level. Replaces the top level's two-state IDLE/RUNNING machine with a four-state session: start, lives, a timed death pause with flashing, game over, and a two-digit BCD level count. Its outputs drive character control, the seven-segment display path and sprite tinting.

## Interface
Parameters:
- C_LIVES_INI, 3: lives at game start. Range 1–3.
- C_DEATH_CYCLES, 25_000_000: length of the DYING pause in clocks. Must be ≥ 2.
- C_FLASH_CYCLES, 3_125_000: half-period of o_Death_Flash in clocks. Must be ≥ 1.

Ports:
- i_Clk  in  1  system clock (25 MHz pixel clock).
- i_Reset  in  1  reset, asynchronous, active-high.
- i_Start  in  1  all four debounced switches ANDed.
- i_Has_Collided  in  1  level, frog overlaps a car.
- i_Level_Up  in  1  frog reached the top row. Level or pulse; rising-edge detected.
- o_Game_Active  out  1  high only in RUNNING.
- o_State  out  2  0=IDLE, 1=RUNNING, 2=DYING, 3=GAME_OVER.
- o_Lives  out  2  remaining lives.
- o_Level_Ones  out  4  BCD ones digit of the level.
- o_Level_Tens  out  4  BCD tens digit of the level.
- o_Respawn  out  1  one-cycle pulse on DYING→RUNNING.
- o_Death_Flash  out  1  blink signal during DYING.
- o_Best_Ones / o_Best_Tens  out  4 each  best level reached (see Configuration).

## Operation
- The block registers i_Start and i_Level_Up each cycle to form rising edges: start_edge = i_Start & ~prev, lvl_edge likewise.
- **IDLE**
  - On start_edge: go to RUNNING; lives ← C_LIVES_INI; level ← 00.
- **RUNNING**
  - i_Has_Collided=1: go to DYING; lives ← lives−1; death counter ← 0.
  - Else lvl_edge: level +1 in BCD. Ones digit wraps 9→0 with tens carry. Level saturates at 99.
  - Collision and lvl_edge in the same cycle: collision wins and the level is not incremented.
- **DYING**
  - i_Has_Collided, i_Start and lvl_edge are ignored.
  - The counter increments each cycle. When it reaches C_DEATH_CYCLES−1:
    - lives==0 → go to GAME_OVER.
    - lives>0 → go to RUNNING and assert o_Respawn for that one cycle.
- **GAME_OVER**
  - Level and lives are frozen for display.
  - On start_edge: go to IDLE; level ← 00.
- A start_edge only counts when i_Start was low the previous cycle. Switches held from the previous state do not retrigger.
- o_Death_Flash:
  - Goes to 1 on entry to DYING.
  - Toggles every C_FLASH_CYCLES cycles.
  - Is 0 in every other state.
- Widths:
  - Death counter is $clog2(C_DEATH_CYCLES) bits.
  - Flash counter is $clog2(C_FLASH_CYCLES) bits.
  - Lives never decrement below 0, because DYING is unreachable with lives==0.

## Timing
- All outputs are registered.
- Reset values (asynchronous):
  - o_State=IDLE, o_Game_Active=0, o_Lives=0.
  - Level digits 0, best digits 0.
  - o_Respawn=0, o_Death_Flash=0.
  - Edge-detect registers 0.
- Input sampled at edge N changes outputs after edge N (1-cycle latency).
- The first rising clock edge after reset deasserts is treated as a normal cycle. If i_Start is already high then, it counts as start_edge.
- DYING lasts exactly C_DEATH_CYCLES cycles: o_State=2 for C_DEATH_CYCLES consecutive samples.
- o_Game_Active returns high in the same cycle o_Respawn is high.
- Reset asserted mid-DYING or mid-RUNNING returns everything to reset values immediately. Best-level registers are cleared too.

## Configuration
- Macro: FROG_SESSION_HIGH_SCORE_EN.
- Defined:
  - On each entry to GAME_OVER, if the level (tens,ones) is greater than best, best ← level.
  - Comparison is on the BCD pair: tens first, then ones.
- Undefined:
  - o_Best_Ones and o_Best_Tens are constant 0.
  - No best-level registers are synthesized.

## Test plan
Bench parameters: C_LIVES_INI=3, C_DEATH_CYCLES=8, C_FLASH_CYCLES=2.

1. Reset then i_Start pulse → one cycle later o_State=1, o_Game_Active=1, o_Lives=3, level 00. Holding i_Start high for 20 cycles produces no further transitions.
2. 12 lvl_edges in RUNNING → Level_Tens=1, Level_Ones=2. Continuing to 105 edges → level saturates at 99.
3. One-cycle collision → o_State=2 for exactly 8 cycles with o_Lives=2 and o_Death_Flash pattern 1,1,0,0,1,1,0,0. Then o_State=1 with o_Respawn high for exactly 1 cycle.
4. Collision and lvl_edge in the same cycle at level 05 → level stays 05, o_Lives decrements. Collision held high throughout DYING causes no further decrement.
5. Three collisions → after the third pause o_State=3, o_Lives=0. i_Start rising edge → IDLE with level 00. A second i_Start edge → RUNNING with lives 3.
6. Macro defined: game over at level 07, then at 04 → best=07 after both. Reset asserted mid-DYING → all outputs are at reset values before the next clock edge.
